// File: rtl/crcu_clk_div_ctrl.sv
// Programmable half-period clock divider with a glitch-free ratio-change sequencer.
// Ratio updates park clk_out low, settle, load the new half-period, then acknowledge.
module crcu_clk_div_ctrl #(
    parameter int unsigned DIV_W        = 8,
    parameter int unsigned DEFAULT_HALF = 4,
    parameter int unsigned SETTLE_CYC   = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             enable_in,
    input  logic             cfg_req_in,
    input  logic [DIV_W-1:0] cfg_half_in,
    output logic             cfg_ack_out,
    output logic             cfg_err_out,
    output logic             clk_out,
    output logic             clk_gated_out,
    output logic             busy_out,
    output logic [DIV_W-1:0] cur_half_out
);

    localparam int unsigned       SetW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SetW-1:0]   SetLast = SetW'(SETTLE_CYC - 1);
    localparam logic [SetW-1:0]   SetOne  = SetW'(1);
    localparam logic [DIV_W-1:0]  DivOne  = DIV_W'(1);
    localparam logic [DIV_W-1:0]  DefHalf = DIV_W'(DEFAULT_HALF);

    typedef enum logic [1:0] {StOff, StRun, StDrain, StSettle} state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic              clk_q, clk_d;
    logic [DIV_W-1:0]  half_q, half_d;
    logic [DIV_W-1:0]  pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic              stop_q, stop_d;
    logic [SetW-1:0]   set_q, set_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              gated_q, gated_d;

    logic              sample_ok, req_ok, req_bad, div_wrap;
    logic [DIV_W-1:0]  cnt_adv;

    // A held request is ignored while a sequence or a response pulse is in flight.
    assign sample_ok = !busy_q && !ack_q && !err_q;
    assign req_ok    = sample_ok && cfg_req_in && (cfg_half_in != '0);
    assign req_bad   = sample_ok && cfg_req_in && (cfg_half_in == '0);
    assign div_wrap  = (cnt_q == half_q - DivOne);
    assign cnt_adv   = div_wrap ? '0 : cnt_q + DivOne;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clk_d      = clk_q;
        half_d     = half_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        stop_d     = stop_q;
        set_d      = set_q;
        ack_d      = 1'b0;
        err_d      = req_bad;

        unique case (state_q)
            StOff: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (req_ok) begin
                    half_d = cfg_half_in;
                    ack_d  = 1'b1;
                end
                if (enable_in) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                cnt_d = cnt_adv;
                if (div_wrap) begin
                    clk_d = ~clk_q;
                end
                if (req_ok) begin
                    pend_d     = cfg_half_in;
                    pend_vld_d = 1'b1;
                    state_d    = StDrain;
                end
                if (!enable_in) begin
                    stop_d  = 1'b1;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Leave only once clk_out is low so the high phase is never cut short.
                if (!clk_q || div_wrap) begin
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                    set_d   = '0;
                    state_d = pend_vld_q ? StSettle : StOff;
                    if (!pend_vld_q) begin
                        stop_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_adv;
                end
            end
            StSettle: begin
                cnt_d = '0;
                clk_d = 1'b0;
                set_d = set_q + SetOne;
                if (set_q == SetLast) begin
                    half_d     = pend_q;
                    ack_d      = 1'b1;
                    pend_vld_d = 1'b0;
                    stop_d     = 1'b0;
                    set_d      = '0;
                    state_d    = (stop_q || !enable_in) ? StOff : StRun;
                end
            end
            default: state_d = StOff;
        endcase

        busy_d  = (state_d == StDrain) || (state_d == StSettle);
        gated_d = (state_d == StOff) || (state_d == StSettle);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= StOff;
            cnt_q      <= '0;
            clk_q      <= 1'b0;
            half_q     <= DefHalf;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            stop_q     <= 1'b0;
            set_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            gated_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clk_q      <= clk_d;
            half_q     <= half_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            stop_q     <= stop_d;
            set_q      <= set_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            gated_q    <= gated_d;
        end
    end

    assign cfg_ack_out   = ack_q;
    assign cfg_err_out   = err_q;
    assign clk_out       = clk_q;
    assign clk_gated_out = gated_q;
    assign busy_out      = busy_q;
    assign cur_half_out  = half_q;

endmodule

// File: tb/tb_crcu_clk_div_ctrl.sv
// Bench for crcu_clk_div_ctrl: scripted phase-length checks plus a scoreboard of
// expected ack/err responses popped whenever the DUT pulses one.
module tb_crcu_clk_div_ctrl;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       cfg_req;
    logic [7:0] cfg_half;
    logic       cfg_ack;
    logic       cfg_err;
    logic       clk_out;
    logic       clk_gated;
    logic       busy;
    logic [7:0] cur_half;

    crcu_clk_div_ctrl #(
        .DIV_W        (8),
        .DEFAULT_HALF (4),
        .SETTLE_CYC   (4)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .enable_in     (enable),
        .cfg_req_in    (cfg_req),
        .cfg_half_in   (cfg_half),
        .cfg_ack_out   (cfg_ack),
        .cfg_err_out   (cfg_err),
        .clk_out       (clk_out),
        .clk_gated_out (clk_gated),
        .busy_out      (busy),
        .cur_half_out  (cur_half)
    );

    typedef struct packed {
        logic       is_err;
        logic [7:0] half;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_level(input logic v, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (clk_out !== v && n < 64);
    endtask

    task automatic wait_ack(output int n, output logic saw_clk);
        n       = 0;
        saw_clk = 1'b0;
        do begin
            tick(1);
            n++;
            saw_clk = saw_clk | clk_out;
        end while (cfg_ack !== 1'b1 && n < 64);
    endtask

    // Response monitor: every ack/err pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (cfg_ack || cfg_err)) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_spurious_pulse", {30'b0, cfg_ack, cfg_err}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("sb_err", {31'b0, cfg_err}, {31'b0, e.is_err});
                check_eq("sb_ack", {31'b0, cfg_ack}, {31'b0, ~e.is_err});
                check_eq("sb_half", {24'b0, cur_half}, {24'b0, e.half});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic s;
        rst      = 1'b1;
        enable   = 1'b0;
        cfg_req  = 1'b0;
        cfg_half = 8'd0;
        tick(3);
        check_eq("rst_clk", {31'b0, clk_out}, 32'd0);
        check_eq("rst_gated", {31'b0, clk_gated}, 32'd1);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_ack", {31'b0, cfg_ack}, 32'd0);
        check_eq("rst_err", {31'b0, cfg_err}, 32'd0);
        check_eq("rst_half", {24'b0, cur_half}, 32'd4);
        rst = 1'b0;
        tick(2);

        // Start: first rise cur_half cycles after RUN entry, then 4/4 phases.
        enable = 1'b1;
        tick(1);
        check_eq("run_gated", {31'b0, clk_gated}, 32'd0);
        check_eq("run_clk0", {31'b0, clk_out}, 32'd0);
        wait_level(1'b1, n);
        check_eq("first_rise", n, 32'd4);
        wait_level(1'b0, n);
        check_eq("high4", n, 32'd4);
        wait_level(1'b1, n);
        check_eq("low4", n, 32'd4);

        // Invalid request: one-cycle err, ratio and waveform untouched.
        cfg_req  = 1'b1;
        cfg_half = 8'd0;
        sb_q.push_back('{is_err: 1'b1, half: 8'd4});
        tick(1);
        check_eq("err_pulse", {31'b0, cfg_err}, 32'd1);
        tick(1);
        check_eq("err_once", {31'b0, cfg_err}, 32'd0);
        cfg_req = 1'b0;
        check_eq("err_half", {24'b0, cur_half}, 32'd4);
        wait_level(1'b0, n);
        check_eq("err_high_rest", n, 32'd2);
        wait_level(1'b1, n);
        check_eq("err_low", n, 32'd4);

        // Stop while high: full high phase, then parked low.
        enable = 1'b0;
        tick(1);
        check_eq("stop_busy", {31'b0, busy}, 32'd1);
        check_eq("stop_clk_hi", {31'b0, clk_out}, 32'd1);
        wait_level(1'b0, n);
        check_eq("stop_high_rest", n, 32'd3);
        check_eq("stop_gated", {31'b0, clk_gated}, 32'd1);
        check_eq("stop_busy_off", {31'b0, busy}, 32'd0);
        tick(4);
        check_eq("stop_parked", {31'b0, clk_out}, 32'd0);
        enable = 1'b1;
        tick(1);
        check_eq("reen_gated", {31'b0, clk_gated}, 32'd0);
        wait_level(1'b1, n);
        check_eq("reen_first_low", n, 32'd4);

        // Ratio change mid-high, request held across its ack.
        tick(1);
        cfg_req  = 1'b1;
        cfg_half = 8'd2;
        sb_q.push_back('{is_err: 1'b0, half: 8'd2});
        wait_level(1'b0, n);
        check_eq("chg_high_rest", n, 32'd3);
        check_eq("chg_settle_gated", {31'b0, clk_gated}, 32'd1);
        check_eq("chg_settle_busy", {31'b0, busy}, 32'd1);
        wait_ack(n, s);
        check_eq("chg_ack_lat", n, 32'd4);
        check_eq("chg_settle_low", {31'b0, s}, 32'd0);
        check_eq("chg_half", {24'b0, cur_half}, 32'd2);
        tick(1);
        cfg_req = 1'b0;
        wait_level(1'b1, n);
        check_eq("chg_first_rise", n, 32'd1);
        wait_level(1'b0, n);
        check_eq("chg_high2", n, 32'd2);
        wait_level(1'b1, n);
        check_eq("chg_low2", n, 32'd2);
        check_eq("chg_no_retrigger", {31'b0, busy}, 32'd0);

        // Request and enable drop together: config applied, then OFF.
        cfg_req  = 1'b1;
        cfg_half = 8'd3;
        enable   = 1'b0;
        sb_q.push_back('{is_err: 1'b0, half: 8'd3});
        wait_ack(n, s);
        check_eq("both_ack_lat", n, 32'd6);
        cfg_req = 1'b0;
        check_eq("both_gated", {31'b0, clk_gated}, 32'd1);
        check_eq("both_clk", {31'b0, clk_out}, 32'd0);
        tick(1);
        check_eq("both_off", {31'b0, clk_gated}, 32'd1);
        check_eq("both_busy", {31'b0, busy}, 32'd0);

        // Reset during SETTLE discards the pending ratio with no ack.
        enable = 1'b1;
        tick(1);
        cfg_req  = 1'b1;
        cfg_half = 8'd5;
        tick(1);
        check_eq("rs_drain_busy", {31'b0, busy}, 32'd1);
        check_eq("rs_drain_gated", {31'b0, clk_gated}, 32'd0);
        tick(1);
        check_eq("rs_settle_gated", {31'b0, clk_gated}, 32'd1);
        rst     = 1'b1;
        cfg_req = 1'b0;
        enable  = 1'b0;
        tick(1);
        check_eq("rs_half", {24'b0, cur_half}, 32'd4);
        check_eq("rs_busy", {31'b0, busy}, 32'd0);
        check_eq("rs_gated", {31'b0, clk_gated}, 32'd1);
        check_eq("rs_ack", {31'b0, cfg_ack}, 32'd0);
        rst = 1'b0;
        tick(8);
        check_eq("rs_half_hold", {24'b0, cur_half}, 32'd4);

        // Request in OFF: 1-cycle ack, then half=1 gives clk_in/2.
        cfg_req  = 1'b1;
        cfg_half = 8'd1;
        sb_q.push_back('{is_err: 1'b0, half: 8'd1});
        tick(1);
        check_eq("off_ack", {31'b0, cfg_ack}, 32'd1);
        check_eq("off_half", {24'b0, cur_half}, 32'd1);
        cfg_req = 1'b0;
        enable  = 1'b1;
        tick(1);
        wait_level(1'b1, n);
        check_eq("div2_rise", n, 32'd1);
        wait_level(1'b0, n);
        check_eq("div2_high", n, 32'd1);
        wait_level(1'b1, n);
        check_eq("div2_low", n, 32'd1);

        tick(2);
        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/crcu_clk_div_ctrl.md
# crcu_clk_div_ctrl

Synthesizable programmable clock divider with a glitch-free ratio-change sequencer for the CRCU. It owns a half-period counter that generates `clk_out` from `clk_in`. It accepts divide-ratio updates over a req/ack handshake: the output is parked low, the divider settles, the new ratio loads, and then the block acknowledges. It also handles clean start/stop via `enable_in`. It is the synthesizable replacement for the behavioural clock source used in simulation and sits between the CRCU register block and downstream clock consumers.

## Interface
- `DIV_W`, 8: width of the half-period value and the counter.
- `DEFAULT_HALF`, 4: half-period (in `clk_in` cycles) loaded at reset; must be in 1..2^DIV_W-1.
- `SETTLE_CYC`, 4: cycles the output is held low before a new ratio loads; must be ≥1.
- `clk_in` in 1: single clock for the whole block.
- `rst_in` in 1: reset, synchronous, active-high.
- `enable_in` in 1: level; 1 runs the divider, 0 requests a clean stop.
- `cfg_req_in` in 1: level; requester holds it high until `cfg_ack_out` or `cfg_err_out`.
- `cfg_half_in` in DIV_W: requested half-period; valid range 1..2^DIV_W-1.
- `cfg_ack_out` out 1: one-cycle pulse; the new ratio is applied.
- `cfg_err_out` out 1: one-cycle pulse; the request was rejected (`cfg_half_in` == 0).
- `clk_out` out 1: registered divided clock with period 2×`cur_half_out` `clk_in` cycles.
- `clk_gated_out` out 1: 1 while the controller forces `clk_out` low (states OFF and SETTLE).
- `busy_out` out 1: 1 while in DRAIN or SETTLE.
- `cur_half_out` out DIV_W: half-period currently in effect.

## Operation
- Divider counter `cnt` runs only in RUN and DRAIN. It counts 0..`cur_half_out`-1; at `cur_half_out`-1 it toggles `clk_out` and wraps to 0. Half = 1 gives `clk_in`/2.
- State OFF: `clk_out`=0, `cnt`=0.
  - `enable_in`=1 → RUN with `cnt`=0.
  - A valid request in OFF loads `cur_half_out` directly, with no settle; `cfg_ack_out` pulses the next cycle, in the same cycle `cur_half_out` shows the new value.
- State RUN: normal division.
  - Valid request → latch `cfg_half_in` into pending, go to DRAIN.
  - `enable_in`=0 → DRAIN with a stop flag.
  - Request and enable drop in the same cycle: the config is taken, and the stop flag is also set.
- State DRAIN: keep dividing until `clk_out`==0.
  - If `clk_out` is already 0, exit on the first DRAIN cycle.
  - If `clk_out` is 1, exit in the cycle its falling toggle is registered.
  - Exit target: SETTLE if a config is pending; otherwise OFF (stop only).
- State SETTLE: `clk_out` held 0, `cnt`=0 for exactly `SETTLE_CYC` cycles. On the last cycle:
  - `cur_half_out` ← pending, `cfg_ack_out` ← 1.
  - Next state is OFF if the stop flag is set or `enable_in`=0, else RUN.
- Request sampling: `cfg_req_in` is sampled only when `busy_out`=0, `cfg_ack_out`=0 and `cfg_err_out`=0, which prevents retriggering by a held request.
  - A request made during DRAIN or SETTLE waits.
- Invalid request (`cfg_half_in`=0) in any state where sampling is allowed: `cfg_err_out` pulses next cycle; no state or ratio change.
- Glitch freedom: `clk_out` changes only from the registered toggle flop. No high phase is ever shortened. Low phases may only be lengthened.
- `enable_in` falling during DRAIN/SETTLE: the sequence completes and acks, then goes to OFF.
- Reset values (any time, including mid-sequence):
  - State OFF, `cur_half_out`=`DEFAULT_HALF`, `clk_out`=0, `cnt`=0.
  - `cfg_ack_out`=0, `cfg_err_out`=0, `busy_out`=0, `clk_gated_out`=1.
  - Pending request and stop flag are discarded; no ack is issued.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Enable sampled at cycle e: RUN from e+1; the first `clk_out` rise is visible at e+1+`cur_half_out`.
- Request sampled at t with `clk_out`=0: DRAIN at t+1, SETTLE at t+2, ack and new `cur_half_out` at t+2+`SETTLE_CYC`.
- Request sampled at t with `clk_out`=1: add the cycles remaining until the falling toggle.
- After ack, RUN restarts with `cnt`=0, so the first high phase under the new ratio begins `cur_half_out` cycles later.
- Error latency: 1 cycle.
- Ack in OFF: 1 cycle.

## Test plan
- Reset, then `enable_in`=1 with `DEFAULT_HALF`=4 → `clk_out` period 8, 50% duty; first rise at 4 cycles after RUN entry; `clk_gated_out` goes 0.
- In RUN with `clk_out` high mid-phase, request half=2 → high phase completes at full length; low is held for 4 settle cycles; ack pulses once; `cur_half_out`=2; then period 4.
- Request with `cfg_half_in`=0 → `cfg_err_out` pulses one cycle; ratio stays 4; `clk_out` undisturbed.
- Drop `enable_in` while `clk_out`=1 → stops at the falling edge; `clk_out` stays 0; `clk_gated_out`=1; re-enable restarts with the 4-cycle first low phase.
- Request held high across its ack → exactly one ack; no second sequence. Request and enable drop in the same cycle → ack, then OFF.
- Assert `rst_in` in SETTLE → next cycle is OFF, `cur_half_out`=4, no ack. In OFF, request half=1 → ack after 1 cycle; after enabling, period is 2.
